// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - host-side received-word and status bundle of uart_rx_param
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
) ();
   logic                 rdy_clr;
   logic                 rdy;
   logic [DATA_BITS-1:0] data;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   // master is the receiver, slave is the host consuming words
   modport master (
      input  rdy_clr,
      output rdy, data, frame_err, parity_err, overrun
   );

   modport slave (
      output rdy_clr,
      input  rdy, data, frame_err, parity_err, overrun
   );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with majority vote,
// false-start rejection, framing/parity/overrun flags and break suppression
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic            clk_50m,
   input  logic            rst_n,
   input  logic            clken,
   input  logic            rx,
   uart_rx_param_if.master host
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam int M  = OVERSAMPLE / 2;

   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_V0   = SW'(M - 1);
   localparam logic [SW-1:0] S_V1   = SW'(M);
   localparam logic [SW-1:0] S_VOTE = SW'(M + 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
   localparam logic          PAR_EXP = (PARITY == 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t               state;
   logic                 rx_m;
   logic                 rx_s;
   logic [SW-1:0]        sample;
   logic [BW-1:0]        bitpos;
   logic [DATA_BITS-1:0] scratch;
   logic                 v0;
   logic                 v1;
   logic                 vote;
   logic                 parity_bad;
   logic                 stop_low;
   logic                 stop_idx;
   logic                 break_hold;
   logic                 final_stop;
   logic                 stop_fail;

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // third vote sample is rx_s live on the M+1 tick, so no extra flop is needed
   always_comb begin
      vote       = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
      final_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
      stop_fail  = stop_low | ~vote;
   end

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         state           <= IDLE;
         sample          <= '0;
         bitpos          <= '0;
         scratch         <= '0;
         v0              <= 1'b1;
         v1              <= 1'b1;
         parity_bad      <= 1'b0;
         stop_low        <= 1'b0;
         stop_idx        <= 1'b0;
         break_hold      <= 1'b0;
         host.rdy        <= 1'b0;
         host.data       <= '0;
         host.frame_err  <= 1'b0;
         host.parity_err <= 1'b0;
         host.overrun    <= 1'b0;
      end else begin
         if (host.rdy_clr) begin
            host.rdy     <= 1'b0;
            host.overrun <= 1'b0;
         end

         if (clken) begin
            if (rx_s) begin
               break_hold <= 1'b0;
            end
            if (sample == S_V0) begin
               v0 <= rx_s;
            end
            if (sample == S_V1) begin
               v1 <= rx_s;
            end
            if (state != IDLE) begin
               sample <= (sample == S_LAST) ? '0 : sample + 1'b1;
            end

            case (state)
               IDLE: begin
                  if (!rx_s && !break_hold) begin
                     state  <= START;
                     sample <= SW'(1);
                  end else begin
                     sample <= '0;
                  end
               end

               START: begin
                  if (sample == S_VOTE && vote) begin
                     state  <= IDLE;
                     sample <= '0;
                  end else if (sample == S_LAST) begin
                     state  <= DATA;
                     bitpos <= '0;
                  end
               end

               DATA: begin
                  if (sample == S_VOTE) begin
                     scratch[bitpos] <= vote;
                  end
                  if (sample == S_LAST) begin
                     if (bitpos == B_LAST) begin
                        state    <= (PARITY != 0) ? PAR : STOP;
                        stop_idx <= 1'b0;
                        stop_low <= 1'b0;
                     end else begin
                        bitpos <= bitpos + 1'b1;
                     end
                  end
               end

               PAR: begin
                  if (sample == S_VOTE) begin
                     parity_bad <= ((^scratch) ^ vote) != PAR_EXP;
                  end
                  if (sample == S_LAST) begin
                     state <= STOP;
                  end
               end

               STOP: begin
                  if (sample == S_VOTE) begin
                     if (final_stop) begin
                        // leave mid-bit so the next start edge is caught with half a bit of margin
                        state           <= IDLE;
                        sample          <= '0;
                        host.data       <= scratch;
                        host.rdy        <= 1'b1;
                        host.frame_err  <= stop_fail;
                        host.parity_err <= (PARITY != 0) && parity_bad;
                        host.overrun    <= host.overrun | (host.rdy & ~host.rdy_clr);
                        break_hold      <= stop_fail && (scratch == '0);
                     end else begin
                        stop_low <= ~vote;
                     end
                  end else if (sample == S_LAST) begin
                     stop_idx <= 1'b1;
                  end
               end

               default: begin
                  state  <= IDLE;
                  sample <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param: 8N1, 7E1 and 8N2 instances
module tb_uart_rx_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clken = 1'b0;
   int   ck_div = 0;
   always @(posedge clk) begin
      ck_div <= (ck_div == 3) ? 0 : ck_div + 1;
      clken  <= (ck_div == 3);
   end

   logic rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
   logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

   uart_rx_param_if #(.DATA_BITS(8)) if0 ();
   uart_rx_param_if #(.DATA_BITS(7)) if1 ();
   uart_rx_param_if #(.DATA_BITS(8)) if2 ();

   uart_rx_param dut0 (
      .clk_50m(clk), .rst_n(rst0), .clken(clken), .rx(rx0), .host(if0)
   );
   uart_rx_param #(.DATA_BITS(7), .PARITY(2)) dut1 (
      .clk_50m(clk), .rst_n(rst1), .clken(clken), .rx(rx1), .host(if1)
   );
   uart_rx_param #(.STOP_BITS(2)) dut2 (
      .clk_50m(clk), .rst_n(rst2), .clken(clken), .rx(rx2), .host(if2)
   );

   int checks = 0;
   int errors = 0;

   int   rc0 = 0, rc1 = 0, rc2 = 0;
   logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
   always @(negedge clk) begin
      if (if0.rdy && !p0) rc0 <= rc0 + 1;
      if (if1.rdy && !p1) rc1 <= rc1 + 1;
      if (if2.rdy && !p2) rc2 <= rc2 + 1;
      p0 <= if0.rdy;
      p1 <= if1.rdy;
      p2 <= if2.rdy;
   end

   task automatic drive(input int sel, input logic v, input int cycles);
      case (sel)
         0: rx0 = v;
         1: rx1 = v;
         default: rx2 = v;
      endcase
      repeat (cycles) @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input logic [8:0] val, input int nbits,
                             input int par, input logic stop_v, input int nstop, input int bc);
      drive(sel, 1'b0, bc);
      for (int i = 0; i < nbits; i++) drive(sel, val[i], bc);
      if (par >= 0) drive(sel, par[0], bc);
      for (int i = 0; i < nstop; i++) drive(sel, stop_v, bc);
      drive(sel, 1'b1, 0);
   endtask

   task automatic clear_rdy(input int sel);
      @(negedge clk);
      case (sel)
         0: if0.rdy_clr = 1'b1;
         1: if1.rdy_clr = 1'b1;
         default: if2.rdy_clr = 1'b1;
      endcase
      @(negedge clk);
      if0.rdy_clr = 1'b0;
      if1.rdy_clr = 1'b0;
      if2.rdy_clr = 1'b0;
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clk);
      checks++; if (if0.rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", if0.rdy); end
      checks++; if (if0.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", if0.data); end
      checks++; if (if0.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", if0.frame_err); end
      checks++; if (if0.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", if0.parity_err); end
      checks++; if (if0.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", if0.overrun); end
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_basic();
      int r;
      r = rc0;
      send_frame(0, 9'h0A5, 8, -1, 1'b1, 1, 64);
      drive(0, 1'b1, 64);
      checks++; if (if0.rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy: got %b expected 1", if0.rdy); end
      checks++; if (if0.data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", if0.data); end
      checks++; if ({if0.frame_err, if0.parity_err, if0.overrun} !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b expected 000", {if0.frame_err, if0.parity_err, if0.overrun}); end
      checks++; if (rc0 !== r + 1) begin errors++; $display("FAIL basic_rdy_count: got %0d expected %0d", rc0, r + 1); end
      clear_rdy(0);
      checks++; if (if0.rdy !== 1'b0) begin errors++; $display("FAIL basic_clear_rdy: got %b expected 0", if0.rdy); end
      checks++; if (if0.data !== 8'hA5) begin errors++; $display("FAIL basic_clear_keeps_data: got %h expected a5", if0.data); end
   endtask

   task automatic test_false_start();
      int r;
      r = rc0;
      drive(0, 1'b0, 20);
      drive(0, 1'b1, 5 * 64);
      checks++; if (rc0 !== r) begin errors++; $display("FAIL false_start_no_rdy: got %0d rdy pulses expected 0", rc0 - r); end
      send_frame(0, 9'h03C, 8, -1, 1'b1, 1, 64);
      drive(0, 1'b1, 64);
      checks++; if (if0.data !== 8'h3C) begin errors++; $display("FAIL false_start_next_data: got %h expected 3c", if0.data); end
      checks++; if (rc0 !== r + 1) begin errors++; $display("FAIL false_start_next_rdy: got %0d expected %0d", rc0, r + 1); end
      clear_rdy(0);
   endtask

   task automatic test_parity();
      send_frame(1, 9'h041, 7, 0, 1'b1, 1, 64);
      drive(1, 1'b1, 64);
      checks++; if (if1.parity_err !== 1'b0) begin errors++; $display("FAIL parity_good_err: got %b expected 0", if1.parity_err); end
      checks++; if (if1.data !== 7'h41) begin errors++; $display("FAIL parity_good_data: got %h expected 41", if1.data); end
      clear_rdy(1);
      send_frame(1, 9'h041, 7, 1, 1'b1, 1, 64);
      drive(1, 1'b1, 64);
      checks++; if (if1.parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad_err: got %b expected 1", if1.parity_err); end
      checks++; if (if1.data !== 7'h41) begin errors++; $display("FAIL parity_bad_data: got %h expected 41", if1.data); end
      checks++; if (if1.rdy !== 1'b1 || if1.frame_err !== 1'b0) begin errors++; $display("FAIL parity_bad_rdy_fe: got %b%b expected 10", if1.rdy, if1.frame_err); end
      clear_rdy(1);
   endtask

   task automatic test_frame_err();
      int r;
      r = rc0;
      send_frame(0, 9'h055, 8, -1, 1'b0, 1, 64);
      drive(0, 1'b1, 2 * 64);
      checks++; if (if0.frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_flag: got %b expected 1", if0.frame_err); end
      checks++; if (if0.rdy !== 1'b1) begin errors++; $display("FAIL frame_err_rdy: got %b expected 1", if0.rdy); end
      checks++; if (if0.data !== 8'h55) begin errors++; $display("FAIL frame_err_data: got %h expected 55", if0.data); end
      checks++; if (rc0 !== r + 1) begin errors++; $display("FAIL frame_err_count: got %0d expected %0d", rc0, r + 1); end
      clear_rdy(0);
   endtask

   task automatic test_break();
      int r;
      r = rc0;
      drive(0, 1'b0, 3 * 10 * 64);
      drive(0, 1'b1, 2 * 64);
      checks++; if (rc0 !== r + 1) begin errors++; $display("FAIL break_one_rdy: got %0d pulses expected 1", rc0 - r); end
      checks++; if (if0.data !== 8'h00) begin errors++; $display("FAIL break_data: got %h expected 00", if0.data); end
      checks++; if (if0.frame_err !== 1'b1) begin errors++; $display("FAIL break_frame_err: got %b expected 1", if0.frame_err); end
      clear_rdy(0);
      send_frame(0, 9'h012, 8, -1, 1'b1, 1, 64);
      drive(0, 1'b1, 64);
      checks++; if (if0.data !== 8'h12) begin errors++; $display("FAIL break_after_data: got %h expected 12", if0.data); end
      checks++; if (if0.frame_err !== 1'b0 || if0.rdy !== 1'b1) begin errors++; $display("FAIL break_after_flags: got fe=%b rdy=%b expected fe=0 rdy=1", if0.frame_err, if0.rdy); end
      clear_rdy(0);
   endtask

   task automatic test_back_to_back();
      send_frame(0, 9'h011, 8, -1, 1'b1, 1, 64);
      send_frame(0, 9'h022, 8, -1, 1'b1, 1, 64);
      drive(0, 1'b1, 64);
      checks++; if (if0.data !== 8'h22) begin errors++; $display("FAIL b2b_data: got %h expected 22", if0.data); end
      checks++; if (if0.overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", if0.overrun); end
      checks++; if (if0.rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy: got %b expected 1", if0.rdy); end
      clear_rdy(0);
      checks++; if (if0.overrun !== 1'b0 || if0.rdy !== 1'b0) begin errors++; $display("FAIL b2b_clear: got ov=%b rdy=%b expected 0 0", if0.overrun, if0.rdy); end
   endtask

   task automatic test_overrun_clear();
      logic found;
      found = 1'b0;
      send_frame(0, 9'h033, 8, -1, 1'b1, 1, 64);
      fork
         send_frame(0, 9'h044, 8, -1, 1'b1, 1, 64);
         begin
            repeat (9 * 64) @(negedge clk);
            if0.rdy_clr = 1'b1;
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               if (if0.rdy === 1'b1) begin
                  found = 1'b1;
                  break;
               end
            end
            if0.rdy_clr = 1'b0;
         end
      join
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL coincide_rdy_seen: got %b expected 1 within 400 cycles", found); end
      drive(0, 1'b1, 64);
      checks++; if (if0.rdy !== 1'b1) begin errors++; $display("FAIL coincide_rdy: got %b expected 1", if0.rdy); end
      checks++; if (if0.overrun !== 1'b0) begin errors++; $display("FAIL coincide_overrun: got %b expected 0", if0.overrun); end
      checks++; if (if0.data !== 8'h44) begin errors++; $display("FAIL coincide_data: got %h expected 44", if0.data); end
      clear_rdy(0);
   endtask

   task automatic test_fast_reset();
      int r;
      send_frame(2, 9'h0C3, 8, -1, 1'b1, 2, 62);
      drive(2, 1'b1, 62);
      checks++; if (if2.data !== 8'hC3 || if2.frame_err !== 1'b0) begin errors++; $display("FAIL fast_c3: got data=%h fe=%b expected c3 0", if2.data, if2.frame_err); end
      clear_rdy(2);
      r = rc2;
      fork
         send_frame(2, 9'h0FF, 8, -1, 1'b1, 2, 62);
         begin
            repeat (4 * 62) @(negedge clk);
            rst2 = 1'b0;
            repeat (2) @(negedge clk);
            rst2 = 1'b1;
         end
      join
      drive(2, 1'b1, 2 * 62);
      checks++; if (rc2 !== r || if2.rdy !== 1'b0) begin errors++; $display("FAIL abort_no_rdy: got pulses=%0d rdy=%b expected 0 0", rc2 - r, if2.rdy); end
      checks++; if (if2.data !== 8'h00) begin errors++; $display("FAIL abort_data_reset: got %h expected 00", if2.data); end
      send_frame(2, 9'h096, 8, -1, 1'b1, 2, 62);
      drive(2, 1'b1, 62);
      checks++; if (if2.data !== 8'h96 || if2.frame_err !== 1'b0) begin errors++; $display("FAIL fast_96: got data=%h fe=%b expected 96 0", if2.data, if2.frame_err); end
      clear_rdy(2);
      send_frame(2, 9'h05A, 8, -1, 1'b1, 2, 62);
      drive(2, 1'b1, 62);
      checks++; if (if2.data !== 8'h5A || if2.rdy !== 1'b1) begin errors++; $display("FAIL fast_5a: got data=%h rdy=%b expected 5a 1", if2.data, if2.rdy); end
      checks++; if (rc2 !== r + 2) begin errors++; $display("FAIL fast_count: got %0d expected %0d", rc2, r + 2); end
   endtask

   initial begin
      if0.rdy_clr = 1'b0;
      if1.rdy_clr = 1'b0;
      if2.rdy_clr = 1'b0;
      test_reset();
      test_basic();
      test_false_start();
      test_parity();
      test_frame_err();
      test_break();
      test_back_to_back();
      test_overrun_clear();
      test_fast_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 receiver.
- Sits between the async rx pin and the host-side byte interface. Shares the baud-rate clken generator with the transmitter.
- Adds the following over the 8N1 receiver:
  - configurable data width, parity, stop bits and oversampling;
  - an input synchroniser and majority-vote sampling;
  - false-start rejection;
  - framing, parity and overrun error flags;
  - break handling.

Parameters:
- DATA_BITS, 8, data bits per frame, legal range 5..9, LSB first.
- OVERSAMPLE, 16, clken ticks per bit, even, legal range 8..32.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk_50m  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- clken  in  1  oversample tick: one-cycle pulse, OVERSAMPLE per bit period.
- rx  in  1  asynchronous serial input; idles high.
- rdy_clr  in  1  host acknowledge; clears rdy and overrun.
- rdy  out  1  frame received; data and error flags valid.
- data  out  DATA_BITS  last received word.
- frame_err  out  1  stop bit sampled low in the last frame.
- parity_err  out  1  parity mismatch in the last frame; always 0 when PARITY = 0.
- overrun  out  1  a frame completed while rdy was still set.

Behaviour:
- Reset:
  - Applies when rst_n is low at a clk_50m edge.
  - Outputs: rdy, data, frame_err, parity_err and overrun all go to 0.
  - Internal: state = IDLE, sample = 0, bitpos = 0; both synchroniser flops = 1.
  - Reset mid-frame abandons the frame without asserting rdy.
- Synchroniser:
  - rx passes through a two-flop synchroniser (rx_s) clocked every clk_50m cycle.
  - All decisions use rx_s only.
- Sample counter:
  - Advances only on clken cycles; range 0..OVERSAMPLE-1; wraps at the bit boundary.
  - Mid-bit ticks are M-1, M and M+1, where M = OVERSAMPLE/2.
  - vote = majority of rx_s captured at those three ticks.
  - The vote is evaluated on the tick at M+1.
- State machine (advances only when clken = 1):
  - IDLE: if rx_s = 0 and break_hold = 0, go to START with sample = 1. Otherwise sample = 0.
  - START: on the vote tick, vote = 1 is a false start; return to IDLE and assert nothing. At sample = OVERSAMPLE-1, go to DATA with bitpos = 0.
  - DATA: on the vote tick, scratch[bitpos] = vote. At the end of the bit, increment bitpos. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else to STOP.
  - PARITY:
    - Vote tick: parity_bad = (XOR of scratch XOR vote) compared with the expected value.
    - Expected value: 1 for odd parity, 0 for even parity.
    - Then go to STOP at end of bit.
  - STOP:
    - With STOP_BITS = 2, the first stop bit is held for its full length; its vote contributes to frame_err.
    - On the vote tick of the final stop bit, the frame completes and the state goes to IDLE immediately. This early return gives a half-bit resync margin.
- Frame completion (registered on that clken cycle):
  - data <= scratch and rdy <= 1.
  - frame_err <= any stop vote = 0.
  - parity_err <= parity_bad.
  - overrun <= overrun | (rdy & ~rdy_clr).
  - The previous data is overwritten.
  - Error flags hold until the next completion or reset.
- Latency: rdy rises one clk_50m cycle after the clken edge at tick M+1 of the final stop bit.
- rdy_clr:
  - When asserted, rdy and overrun go to 0 in the next cycle.
  - If a completion coincides with rdy_clr, completion wins: rdy = 1 and overrun is not set.
  - data and the error flags are unaffected by rdy_clr.
- Break:
  - A completion with frame_err = 1 and scratch all zeros sets break_hold.
  - While break_hold = 1, IDLE ignores rx_s = 0.
  - break_hold clears on the first clken with rx_s = 1.
- clken = 0: all state, counters and scratch hold. rdy_clr and reset still act.

Test Plan:
- Default parameters, clken every 4 cycles, send 0xA5 8N1 with correct timing:
  - Expect rdy = 1, data = 0xA5, all error flags 0.
  - rdy_clr then gives rdy = 0 next cycle.
- rx low for 5 ticks (under half a bit), then high:
  - Expect no rdy and state back in IDLE.
  - Then send 0x3C; expect data = 0x3C.
- PARITY = 2, DATA_BITS = 7:
  - Send 0x41 with parity 0; expect parity_err = 0.
  - Resend with parity 1; expect parity_err = 1, data = 0x41.
- Frame 0x55 with stop bit forced low: expect frame_err = 1, rdy = 1.
- Break test:
  - Hold rx low for 3 frame times: expect exactly one rdy, data = 0x00, frame_err = 1.
  - Raise rx, then send 0x12: expect a clean receive.
- Overrun and timing stress:
  - Two back-to-back frames 0x11 then 0x22 without rdy_clr: expect data = 0x22, overrun = 1.
  - Repeat with rdy_clr on the completion cycle of the second frame: expect rdy = 1, overrun = 0.
  - Transmitter baud 3% fast, STOP_BITS = 2, pulse rst_n low mid-frame: expect clean receives at 3% and no rdy from the aborted frame.
